// File: rtl/flex_uart_pkg.sv
// Shared types and line levels for the flex serial peripherals.
package flex_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/flex_uart_tx_if.sv
// Valid/ready word handshake feeding the serial transmitter.
interface flex_uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/flex_bit_timer.sv
// Rollover bit-period counter: counts 1..rollover_val_i, wrapping back to 1.
module flex_bit_timer #(
    parameter int NUM_CNT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    load_i,
    input  logic                    en_i,
    input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
    output logic                    rollover_o
);
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    assign rollover_o = en_i && (count_q == rollover_val_i);

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (load_i || rollover_o) begin
            count_d = CNT_ONE;
        end else if (en_i) begin
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge.
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/flex_uart_tx.sv
// Serial transmitter: start, LSB-first data, optional parity, stop; bit period from clk_div.
module flex_uart_tx
    import flex_uart_pkg::*;
#(
    parameter int NUM_CNT_BITS = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_CNT_BITS-1:0] clk_div,
    input  logic                    parity_en,
    input  logic                    parity_odd,
    flex_uart_tx_if.slave           tx_if,
    output logic                    tx_serial,
    output logic                    busy,
    output logic                    done
);
    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    tx_state_t                state_q, state_d;
    logic [DATA_BITS-1:0]     shift_q, shift_d;
    logic [IDX_W-1:0]         bit_idx_q, bit_idx_d;
    logic [NUM_CNT_BITS-1:0]  div_q;
    logic                     par_en_q, par_bit_q;
    logic                     tx_serial_q, tx_serial_d;
    logic                     done_q, done_d;
    logic                     roll, accept;

    assign busy           = (state_q != IDLE);
    assign tx_if.tx_ready = (state_q == IDLE) || ((state_q == STOP) && roll);
    assign accept         = tx_if.tx_valid && tx_if.tx_ready;
    assign tx_serial      = tx_serial_q;
    assign done           = done_q;

    flex_bit_timer #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_bit_timer (
        .clk            (clk),
        .n_rst          (n_rst),
        .load_i         (accept),
        .en_i           (busy),
        .rollover_val_i (div_q),
        .rollover_o     (roll)
    );

    // tx_serial_d is the level for the state being entered, so the line is registered.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        tx_serial_d = tx_serial_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d     = START;
                shift_d     = tx_if.tx_data;
                tx_serial_d = UART_START_LEVEL;
            end
            START: if (roll) begin
                state_d     = DATA;
                bit_idx_d   = '0;
                tx_serial_d = shift_q[0];
            end
            DATA: if (roll) begin
                if (bit_idx_q == LAST_IDX) begin
                    state_d     = par_en_q ? PARITY : STOP;
                    tx_serial_d = par_en_q ? par_bit_q : UART_IDLE_LEVEL;
                end else begin
                    bit_idx_d   = bit_idx_q + IDX_ONE;
                    shift_d     = shift_q >> 1;
                    tx_serial_d = shift_q[1];
                end
            end
            PARITY: if (roll) begin
                state_d     = STOP;
                tx_serial_d = UART_IDLE_LEVEL;
            end
            STOP: if (roll) begin
                done_d = 1'b1;
                if (accept) begin
                    state_d     = START;
                    shift_d     = tx_if.tx_data;
                    tx_serial_d = UART_START_LEVEL;
                end else begin
                    state_d     = IDLE;
                    tx_serial_d = UART_IDLE_LEVEL;
                end
            end
            default: begin
                state_d     = IDLE;
                tx_serial_d = UART_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            div_q       <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            tx_serial_q <= UART_IDLE_LEVEL;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            tx_serial_q <= tx_serial_d;
            done_q      <= done_d;
            if (accept) begin
                div_q     <= (clk_div == '0) ? NUM_CNT_BITS'(1) : clk_div;
                par_en_q  <= parity_en;
                par_bit_q <= (^tx_if.tx_data) ^ parity_odd;
            end
        end
    end
endmodule

// File: tb/tb_flex_uart_tx.sv
// Scoreboard bench for flex_uart_tx: driver pushes expected frames, monitor decodes the line.
module tb_flex_uart_tx;
    localparam int NCB = 16;
    localparam int DB  = 8;

    typedef struct {
        logic [DB-1:0] data;
        int            d;
        bit            pen;
        bit            par;
    } exp_t;

    logic           clk = 1'b0;
    logic           n_rst;
    logic [NCB-1:0] clk_div;
    logic           parity_en, parity_odd;
    logic           tx_serial, busy, done;
    int             checks = 0;
    int             errors = 0;
    exp_t           sb_q[$];

    flex_uart_tx_if #(.DATA_BITS(DB)) tx_if ();

    flex_uart_tx #(.NUM_CNT_BITS(NCB), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clk_div    (clk_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .tx_if      (tx_if),
        .tx_serial  (tx_serial),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DB-1:0] w, input int div, input bit pen, input bit podd,
                        input bit hold);
        bit   ok;
        exp_t e;
        @(negedge clk);
        tx_if.tx_data  = w;
        tx_if.tx_valid = 1'b1;
        clk_div        = NCB'(div);
        parity_en      = pen;
        parity_odd     = podd;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tx_if.tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_ready", 32'(ok), 32'd1);
        if (ok) begin
            e.data = w;
            e.d    = (div == 0) ? 1 : div;
            e.pen  = pen;
            e.par  = (^w) ^ podd;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        if (!hold) tx_if.tx_valid = 1'b0;
    endtask

    task automatic recv(input bit skip_wait, input bit expect_more);
        bit   found;
        exp_t e;
        int   n, busy_cnt, ready_cnt, done_cnt;
        logic ready_last, obs;
        logic lv[12];
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(skip_wait && i == 0)) @(negedge clk);
            if (tx_serial === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("start_seen", 32'(found), 32'd1);
        if (!found) return;
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        n = 0;
        lv[n++] = 1'b0;
        for (int b = 0; b < DB; b++) lv[n++] = e.data[b];
        if (e.pen) lv[n++] = e.par;
        lv[n++] = 1'b1;
        busy_cnt = 0; ready_cnt = 0; done_cnt = 0; ready_last = 1'b0;
        for (int b = 0; b < n; b++) begin
            obs = lv[b];
            for (int c = 0; c < e.d; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (tx_serial !== lv[b]) obs = tx_serial;
                busy_cnt  += int'(busy === 1'b1);
                ready_cnt += int'(tx_if.tx_ready === 1'b1);
                if (b != 0 || c != 0) done_cnt += int'(done === 1'b1);
                if (b == n - 1 && c == e.d - 1) ready_last = tx_if.tx_ready;
            end
            check($sformatf("bit%0d", b), 32'(obs), 32'(lv[b]));
        end
        check("busy_cycles", 32'(busy_cnt), 32'(n * e.d));
        check("ready_cycles", 32'(ready_cnt), 32'd1);
        check("ready_last", 32'(ready_last), 32'd1);
        check("done_in_frame", 32'(done_cnt), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        if (!expect_more) begin
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ready", 32'(tx_if.tx_ready), 32'd1);
            check("idle_line", 32'(tx_serial), 32'd1);
            @(negedge clk);
            check("done_single", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        n_rst          = 1'b0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        clk_div        = '0;
        parity_en      = 1'b0;
        parity_odd     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_line", 32'(tx_serial), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(tx_if.tx_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        n_rst = 1'b1;

        send(8'hA5, 4, 1'b0, 1'b0, 1'b0); recv(1'b0, 1'b0);
        send(8'hA5, 3, 1'b1, 1'b0, 1'b0); recv(1'b0, 1'b0);
        send(8'hA5, 3, 1'b1, 1'b1, 1'b0); recv(1'b0, 1'b0);
        send(8'h07, 3, 1'b1, 1'b0, 1'b0); recv(1'b0, 1'b0);
        send(8'h01, 0, 1'b0, 1'b0, 1'b0); recv(1'b0, 1'b0);

        fork
            begin
                send(8'h55, 2, 1'b0, 1'b0, 1'b1);
                send(8'hAA, 2, 1'b0, 1'b0, 1'b0);
            end
            begin
                recv(1'b0, 1'b1);
                recv(1'b1, 1'b0);
            end
        join

        // Inputs change right after accept; the frame must keep its latched settings.
        send(8'h3C, 4, 1'b0, 1'b0, 1'b0);
        clk_div       = NCB'(8);
        tx_if.tx_data = 8'hFF;
        parity_en     = 1'b1;
        recv(1'b0, 1'b0);
        send(8'h96, 8, 1'b0, 1'b0, 1'b0); recv(1'b0, 1'b0);

        send(8'hA5, 4, 1'b0, 1'b0, 1'b0);
        repeat (18) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        check("abort_line", 32'(tx_serial), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(tx_if.tx_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            stray += int'(done !== 1'b0) + int'(tx_serial !== 1'b1);
        end
        check("abort_quiet", 32'(stray), 32'd0);
        void'(sb_q.pop_front());
        send(8'h3B, 2, 1'b1, 1'b1, 1'b0); recv(1'b0, 1'b0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/flex_uart_tx.md
Name: flex_uart_tx

Overview:
- Serial asynchronous transmitter with a runtime-programmable bit period. It is the transmit-side counterpart to the flex-counter-timed serial receivers in the peripheral subsystem.
- Accepts parallel words over a valid/ready handshake and shifts them out LSB-first.
- Frame: one start bit, DATA_BITS data bits, an optional parity bit, one stop bit.
- Bit timing comes from an internal rollover-style bit-period counter loaded from clk_div.

Parameters:
- NUM_CNT_BITS, 16, width of the clk_div bit-period divisor.
- DATA_BITS, 8, data bits per frame (legal range 5..9).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- n_rst  in  1  reset, synchronous, active-low.
- clk_div  in  NUM_CNT_BITS  clk cycles per serial bit.
- parity_en  in  1  1 = insert a parity bit after the data bits.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- tx_data  in  DATA_BITS  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a word this cycle.
- tx_serial  out  1  serial line; idles high.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse after a frame's stop bit completes.

Behaviour:
- Reset: all state updates only on a clk edge with n_rst=0.
  - State=IDLE, tx_serial=1, busy=0, done=0, tx_ready=1, bit counter=0.
  - Reset asserted mid-frame aborts the frame immediately. Line returns high on that edge, with no partial stop bit and no done pulse.
- Accept: a transfer occurs on an edge where tx_valid=1 && tx_ready=1.
  - On that edge, latch tx_data, clk_div, parity_en and parity_odd into frame registers.
  - Later changes to these inputs do not affect the frame in flight.
  - Effective divisor D = latched clk_div, except clk_div=0 is treated as D=1.
- States: IDLE -> START -> DATA -> (PARITY if parity_en) -> STOP -> IDLE or START.
  - tx_serial is registered. In the cycle after accept it is 0 (start bit).
  - Each bit state holds its value for exactly D cycles.
  - DATA sends bit 0 first, then bits up to DATA_BITS-1. A bit index counter advances at each bit-period rollover.
  - PARITY value = XOR of the data bits, XOR parity_odd.
  - STOP drives 1 for D cycles.
- Bit-period counter:
  - Counts 1..D; rollover fires when count==D.
  - Reloads to 1 at each state entry, so there is no drift between bits.
- Frame length: D*(DATA_BITS+2+parity_en) cycles from the first start-bit cycle to the last stop-bit cycle.
- tx_ready:
  - 1 in IDLE.
  - 1 in the final cycle of STOP, which allows back-to-back frames: on accept, next state is START with no idle gap.
  - 0 otherwise.
- busy: 1 in every state except IDLE.
- done: 1 for exactly one cycle, the cycle after the last STOP cycle. This holds whether the next state is IDLE or START.
- tx_valid while tx_ready=0 is ignored. The transmitter never reads tx_data except on accept.

Decomposition:
- Shared package flex_uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Constants: UART_IDLE_LEVEL=1'b1, UART_START_LEVEL=1'b0.
- Sub-module flex_bit_timer:
  - Parameterised NUM_CNT_BITS counter with load/clear, enable and rollover-at-value output.
  - Shares its structure with the flex counters the receivers use, so it is reusable on both sides.

Test Plan:
- clk_div=4, parity_en=0, send 0xA5.
  - tx_serial = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; 40 cycles total.
  - done pulses once on cycle 41; busy is high for cycles 1..40.
- clk_div=3, parity_en=1.
  - 0xA5 with parity_odd=0: parity bit 0.
  - 0xA5 with parity_odd=1: parity bit 1.
  - 0x07 with parity_odd=0: parity bit 1.
  - Each frame is 33 cycles.
- clk_div=0, send 0x01.
  - One cycle per bit: 0,1,0,0,0,0,0,0,0,1; 10 cycles total.
- Back-to-back: hold tx_valid=1 with 0x55 then 0xAA at clk_div=2.
  - tx_ready is high only in the last STOP cycle.
  - The second start bit immediately follows the first stop bit; done pulses twice, 20 cycles apart.
- Change clk_div from 4 to 8 and tx_data after accept.
  - The in-flight frame keeps D=4 and its original data.
  - The next frame uses D=8.
- Pull n_rst low during bit 3 of DATA for one edge.
  - Next cycle: tx_serial=1, busy=0, tx_ready=1, no done pulse.
  - A fresh frame then transmits correctly.
